// File: rtl/prog_square_wave_meas_pkg.sv
// Shared definitions for the square-wave measurement block.
package prog_square_wave_meas_pkg;

  localparam int unsigned UNIT_DEF = 5;
  localparam int unsigned CW_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/prog_square_wave_meas_sync_2ff.sv
// Two-flop synchronizer for the asynchronous wave input.
module prog_square_wave_meas_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/prog_square_wave_meas.sv
// Measures high/low times of an incoming square wave in cycles and generator units,
// emitting one result per complete period.
module prog_square_wave_meas
  import prog_square_wave_meas_pkg::*;
#(
  parameter int unsigned UNIT = UNIT_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wv,
  output logic [CW-1:0] hi_cycles,
  output logic [CW-1:0] lo_cycles,
  output logic [CW-1:0] m_out,
  output logic [CW-1:0] n_out,
  output logic          exact,
  output logic          valid,
  output logic          locked,
  output logic          err
);

  state_t        state, state_nxt;
  logic          wv_s, wv_d;
  logic          rise_c, fall_c, edge_c, full_c, primed_c;
  logic          start_c, cap_hi_c, cap_lo_c, ovf_c;
  logic [1:0]    prime_cnt;
  logic [CW-1:0] cnt, pre, ucnt;
  logic [CW-1:0] hi_cap, hu_cap;
  logic          hx;

  prog_square_wave_meas_sync_2ff u_sync_2ff (
    .clk   (clk),
    .reset (reset),
    .d     (wv),
    .q     (wv_s)
  );

  // wv_s only reflects the pin once the synchronizer has filled after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wv_d      <= 1'b0;
      prime_cnt <= 2'd0;
    end else begin
      wv_d <= wv_s;
      if (prime_cnt != 2'd2) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign rise_c   = wv_s & ~wv_d;
  assign fall_c   = ~wv_s & wv_d;
  assign edge_c   = rise_c | fall_c;
  assign full_c   = (cnt == {CW{1'b1}});
  assign primed_c = (prime_cnt == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (primed_c && !wv_s && !wv_d) state_nxt = ST_ARM;
      ST_ARM:  if (rise_c) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (fall_c)                 state_nxt = ST_LOW;
        else if (full_c && !edge_c) state_nxt = ST_IDLE;
      end
      ST_LOW: begin
        if (rise_c)                 state_nxt = ST_HIGH;
        else if (full_c && !edge_c) state_nxt = ST_ARM;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_c  = 1'b0;
    cap_hi_c = 1'b0;
    cap_lo_c = 1'b0;
    ovf_c    = 1'b0;
    case (state)
      ST_ARM: start_c = rise_c;
      ST_HIGH: begin
        if (fall_c) begin
          start_c  = 1'b1;
          cap_hi_c = 1'b1;
        end else if (full_c && !edge_c) begin
          ovf_c = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise_c) begin
          start_c  = 1'b1;
          cap_lo_c = 1'b1;
        end else if (full_c && !edge_c) begin
          ovf_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // pre tracks cnt mod UNIT and ucnt tracks cnt / UNIT without a divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      pre  <= '0;
      ucnt <= '0;
    end else if (start_c) begin
      cnt  <= CW'(1);
      pre  <= CW'(1);
      ucnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      if (pre == CW'(UNIT - 1)) begin
        pre  <= '0;
        ucnt <= ucnt + CW'(1);
      end else begin
        pre <= pre + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cap    <= '0;
      hu_cap    <= '0;
      hx        <= 1'b0;
      hi_cycles <= '0;
      lo_cycles <= '0;
      m_out     <= '0;
      n_out     <= '0;
      exact     <= 1'b0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= cap_lo_c;
      err   <= ovf_c;
      if (cap_hi_c) begin
        hi_cap <= cnt;
        hu_cap <= ucnt;
        hx     <= (pre == '0);
      end
      if (cap_lo_c) begin
        hi_cycles <= hi_cap;
        lo_cycles <= cnt;
        m_out     <= hu_cap;
        n_out     <= ucnt;
        exact     <= hx & (pre == '0);
        locked    <= 1'b1;
      end else if (ovf_c) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_square_wave_meas.sv
// Scoreboard bench for prog_square_wave_meas (UNIT=5, CW=8 so overflow is reachable).
module tb_prog_square_wave_meas;

  localparam int unsigned UNIT = 5;
  localparam int unsigned CW   = 8;

  typedef struct {
    logic [CW-1:0] hi;
    logic [CW-1:0] lo;
    logic [CW-1:0] m;
    logic [CW-1:0] n;
    logic          ex;
    logic          chk_gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wv;
  logic [CW-1:0] hi_cycles, lo_cycles, m_out, n_out;
  logic          exact, valid, locked, err;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    last_valid_cyc = 0;
  int    n_valid  = 0;
  int    err_seen = 0;
  time   err_time = 0;
  bit    last_pushed = 1'b0;

  prog_square_wave_meas #(.UNIT(UNIT), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wv        (wv),
    .hi_cycles (hi_cycles),
    .lo_cycles (lo_cycles),
    .m_out     (m_out),
    .n_out     (n_out),
    .exact     (exact),
    .valid     (valid),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  // Scoreboard consumer: every valid pops one expected period
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (err) begin
      err_seen++;
      err_time = $time;
    end
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi_cycles", hi_cycles, e.hi);
        check("lo_cycles", lo_cycles, e.lo);
        check("m_out", m_out, e.m);
        check("n_out", n_out, e.n);
        check("exact", exact, e.ex);
        check("locked_on_valid", locked, 1'b1);
        if (e.chk_gap) check("valid_gap", 64'(cyc - last_valid_cyc), 64'(e.hi + e.lo));
      end
      last_valid_cyc = cyc;
    end
  end

  task automatic hold(input logic v, input int cycles);
    wv = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic period(input int h, input int l, input bit push);
    exp_t e;
    if (push) begin
      e.hi      = CW'(h);
      e.lo      = CW'(l);
      e.m       = CW'(h / int'(UNIT));
      e.n       = CW'(l / int'(UNIT));
      e.ex      = ((h % int'(UNIT)) == 0) && ((l % int'(UNIT)) == 0);
      e.chk_gap = last_pushed;
      exp_q.push_back(e);
    end
    last_pushed = push;
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic tail_and_drain();
    int i;
    hold(1'b1, 6);
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    last_pushed = 1'b0;
  endtask

  task automatic do_reset(input logic level);
    reset = 1'b1;
    wv    = level;
    repeat (3) @(negedge clk);
    check("reset_outputs", {hi_cycles, lo_cycles, m_out, n_out, exact, valid, locked, err}, 64'd0);
    exp_q.delete();
    last_pushed = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int e0, v0;
    time t0;
    reset = 1'b1;
    wv    = 1'b0;
    @(negedge clk);

    // Looped generator m=5, n=6
    do_reset(1'b0);
    hold(1'b0, 10);
    repeat (5) period(25, 30, 1'b1);
    tail_and_drain();
    check("t1_no_err", 64'(err_seen), 64'd0);

    // Direct drive, non-multiple times
    do_reset(1'b0);
    hold(1'b0, 5);
    repeat (2) period(27, 13, 1'b1);
    tail_and_drain();
    check("t2_result_holds", hi_cycles, 64'd27);

    // High at reset release is discarded
    do_reset(1'b1);
    v0 = n_valid;
    hold(1'b1, 20);
    hold(1'b0, 10);
    period(10, 10, 1'b1);
    tail_and_drain();
    check("t3_one_valid", 64'(n_valid - v0), 64'd1);

    // Stuck low after a valid period -> single overflow
    do_reset(1'b0);
    hold(1'b0, 5);
    e0 = err_seen;
    period(20, 15, 1'b1);
    hold(1'b1, 20);
    last_pushed = 1'b0;
    t0 = $time;
    hold(1'b0, 300);
    check("t4_err_count", 64'(err_seen - e0), 64'd1);
    check("t4_err_time", 64'(err_time - t0), 64'd2580);
    check("t4_unlocked", locked, 1'b0);
    period(25, 10, 1'b1);
    tail_and_drain();
    check("t4_relocked", locked, 1'b1);

    // Reset in the middle of a high phase
    do_reset(1'b0);
    hold(1'b0, 5);
    period(20, 10, 1'b1);
    hold(1'b1, 8);
    check("t5_pre_reset_drained", 64'(exp_q.size()), 64'd0);
    #3 reset = 1'b1;
    #1 check("t5_async_reset_outputs",
             {hi_cycles, lo_cycles, m_out, n_out, exact, valid, locked, err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_pushed = 1'b0;
    v0 = n_valid;
    hold(1'b1, 10);
    hold(1'b0, 10);
    period(15, 20, 1'b1);
    tail_and_drain();
    check("t5_one_valid", 64'(n_valid - v0), 64'd1);

    // On-the-fly period change
    do_reset(1'b0);
    hold(1'b0, 5);
    e0 = err_seen;
    repeat (3) period(10, 15, 1'b1);
    repeat (3) period(35, 5, 1'b1);
    tail_and_drain();
    check("t6_no_err", 64'(err_seen - e0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
